// File: rtl/dma_row_packer_pkg.sv
// Shared types and sizing for the DMA row packer: row width, FIFO entry, FSM states.
// No logic, no latency.
// No flow control of its own.
package dma_pkg;
  localparam int WORD_W        = 32;
  localparam int ELEM_W        = 8;
  localparam int ROW_ELEMS     = 16;
  localparam int FIFO_DEPTH    = 4;   // power of two, >= 2
  localparam int ROW_W         = ROW_ELEMS * ELEM_W;
  localparam int WORDS_PER_ROW = ROW_W / WORD_W;
  localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
  localparam int SLOT_W        = $clog2(WORDS_PER_ROW);

  typedef logic [ROW_W-1:0] row_t;

  typedef struct packed {
    row_t data;
    logic last;
  } row_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STALL
  } pack_state_e;
endpackage

// File: rtl/dma_row_packer_if.sv
// Bundle of the DMA word input, the row output handshake, and status/control signals.
// No logic, no latency.
// Row side is valid/ready; DMA side is throttled through hold_req_o.
interface dma_row_packer_if;
  import dma_pkg::*;

  logic              flush_i;
  logic              in_valid_i;
  logic [WORD_W-1:0] in_data_i;
  logic              in_last_i;
  logic              hold_req_o;
  logic              row_valid_o;
  logic              row_ready_i;
  row_t              row_data_o;
  logic              row_last_o;
  logic [CNT_W-1:0]  row_count_o;
  logic              overflow_err_o;

  // Source/consumer side (drives words, accepts rows)
  modport master (
    output flush_i, in_valid_i, in_data_i, in_last_i, row_ready_i,
    input  hold_req_o, row_valid_o, row_data_o, row_last_o, row_count_o, overflow_err_o
  );

  // Packer side
  modport slave (
    input  flush_i, in_valid_i, in_data_i, in_last_i, row_ready_i,
    output hold_req_o, row_valid_o, row_data_o, row_last_o, row_count_o, overflow_err_o
  );
endinterface

// File: rtl/dma_row_packer_row_fifo.sv
// Synchronous FIFO of assembled rows with first-word-fall-through head and occupancy count.
// Latency: a push at edge N is visible at the head after edge N when the FIFO was empty.
// Caller must only push with space (or with a same-cycle pop) and only pop when non-empty.
module row_fifo
  import dma_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  row_entry_t       push_data,
  input  logic             pop,
  output row_entry_t       head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  row_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers and occupancy; push and pop on the same edge leave count unchanged
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; the head is masked by the top while empty.
  // When full, a simultaneous push overwrites the slot being popped, which is safe.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/dma_row_packer.sv
// Packs 32-bit DMA words into 128-bit int8 rows and queues them for the array input loader.
// Latency: the completing word accepted at edge N lands in the FIFO at that same edge; row_valid_o rises right after it.
// Backpressure: registered hold_req_o at occupancy >= DEPTH-1 or stall; a completed row with no space is held in S_STALL.
module dma_row_packer
  import dma_pkg::*;
(
  input logic             clk,
  input logic             rst,
  dma_row_packer_if.slave bus
);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HOLD_CNT  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORDS_PER_ROW - 1);

  pack_state_e       state, state_nxt;
  logic [SLOT_W-1:0] word_cnt;
  row_t              asm_row, asm_fill;
  logic              asm_last;
  row_entry_t        fifo_head, push_data;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              accept, row_done, pop, space, push, clear;
  logic              hold_q, ovf_q;

  assign clear     = bus.flush_i;
  assign pop       = (count != '0) && bus.row_ready_i;
  assign space     = (count != FULL_CNT) || pop;
  assign accept    = bus.in_valid_i && (state != S_STALL);
  assign row_done  = accept && (bus.in_last_i || (word_cnt == LAST_SLOT));
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);

  // Drop the incoming word into its slot; slots above stay zero for padding
  always_comb begin
    asm_fill = asm_row;
    for (int k = 0; k < WORDS_PER_ROW; k++) begin
      if (word_cnt == SLOT_W'(k)) asm_fill[k*WORD_W +: WORD_W] = bus.in_data_i;
    end
  end

  // Next state and FIFO push decision
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = '{data: asm_row, last: asm_last};
    unique case (state)
      S_IDLE, S_FILL: begin
        if (accept) begin
          if (row_done) begin
            push_data = '{data: asm_fill, last: bus.in_last_i};
            if (space) begin
              push      = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_STALL;
            end
          end else begin
            state_nxt = S_FILL;
          end
        end
      end
      S_STALL: begin
        if (space) begin
          push      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, assembly register and slot counter
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      asm_row  <= '0;
      asm_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        asm_row  <= '0;
        asm_last <= 1'b0;
        word_cnt <= '0;
      end else if (row_done) begin
        asm_row  <= asm_fill;
        asm_last <= bus.in_last_i;
        word_cnt <= '0;
      end else if (accept) begin
        asm_row  <= asm_fill;
        word_cnt <= word_cnt + SLOT_W'(1);
      end
    end
  end

  // Registered DMA throttle and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hold_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      hold_q <= (count_nxt >= HOLD_CNT) || (state_nxt == S_STALL);
      if (bus.in_valid_i && (state == S_STALL)) ovf_q <= 1'b1;
    end
  end

  row_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (count)
  );

  assign bus.row_valid_o    = (count != '0);
  assign bus.row_data_o     = bus.row_valid_o ? fifo_head.data : '0;
  assign bus.row_last_o     = bus.row_valid_o ? fifo_head.last : 1'b0;
  assign bus.row_count_o    = count;
  assign bus.hold_req_o     = hold_q;
  assign bus.overflow_err_o = ovf_q;
endmodule

// File: tb/tb_dma_row_packer.sv
// Directed bench for dma_row_packer: vector table for single rows, sequences for queueing, stall, reset and flush.
module tb_dma_row_packer;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_row_packer_if bus();

  dma_row_packer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        r;
    logic        ev;
    logic [127:0] ed;
    logic        el;
    logic [2:0]  ec;
    logic        eh;
  } vec_t;

  vec_t vecs[12];

  localparam logic [127:0] ROW_FULL = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] ROW_PART = {64'h0, 32'h22222222, 32'h11111111};
  localparam logic [127:0] ROW_ONE  = {96'h0, 32'h44444444};

  function automatic vec_t mkv(input logic v, input logic [31:0] d, input logic l, input logic r,
                               input logic ev, input logic [127:0] ed, input logic el,
                               input logic [2:0] ec, input logic eh);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.r = r;
    t.ev = ev; t.ed = ed; t.el = el; t.ec = ec; t.eh = eh;
    return t;
  endfunction

  function automatic logic [31:0] w(input int tag, input int i);
    return (32'(tag) << 24) | 32'(i);
  endfunction

  function automatic logic [127:0] row(input int tag, input int r);
    return {w(tag, 4*r+3), w(tag, 4*r+2), w(tag, 4*r+1), w(tag, 4*r)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    bus.in_valid_i  = v;
    bus.in_data_i   = d;
    bus.in_last_i   = l;
    bus.row_ready_i = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic [127:0] ed, input logic el,
                            input logic [2:0] ec, input logic eh, input logic eo);
    chk({tag, ".valid"}, 128'(bus.row_valid_o), 128'(ev));
    chk({tag, ".data"},  bus.row_data_o, ed);
    chk({tag, ".last"},  128'(bus.row_last_o), 128'(el));
    chk({tag, ".count"}, 128'(bus.row_count_o), 128'(ec));
    chk({tag, ".hold"},  128'(bus.hold_req_o), 128'(eh));
    chk({tag, ".ovf"},   128'(bus.overflow_err_o), 128'(eo));
  endtask

  // Fill the FIFO with four full rows of the given tag while the consumer is stalled
  task automatic fill_four(input int tag);
    for (int i = 0; i < 16; i++) drive(1'b1, w(tag, i), 1'b0, 1'b0);
  endtask

  // Pop and check rows in order
  task automatic drain_check(input string tag, input logic [127:0] exp_row, input logic [2:0] cnt_after);
    chk({tag, ".head"}, bus.row_data_o, exp_row);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    chk({tag, ".cnt"}, 128'(bus.row_count_o), 128'(cnt_after));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 32'h0;
    bus.in_last_i   = 1'b0;
    bus.row_ready_i = 1'b1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    expect_out("reset", 1'b0, 128'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single-row vectors: full row, partial row, held head, single-word row
    vecs[0]  = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[1]  = mkv(1'b1, 32'h03020100, 1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[2]  = mkv(1'b1, 32'h07060504, 1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[3]  = mkv(1'b1, 32'h0B0A0908, 1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[4]  = mkv(1'b1, 32'h0F0E0D0C, 1'b1, 1'b1, 1'b1, ROW_FULL, 1'b1, 3'd1, 1'b0);
    vecs[5]  = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[6]  = mkv(1'b1, 32'h11111111, 1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);
    vecs[7]  = mkv(1'b1, 32'h22222222, 1'b1, 1'b1, 1'b1, ROW_PART, 1'b1, 3'd1, 1'b0);
    vecs[8]  = mkv(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, ROW_PART, 1'b1, 3'd1, 1'b0);
    vecs[9]  = mkv(1'b1, 32'h44444444, 1'b1, 1'b0, 1'b1, ROW_PART, 1'b1, 3'd2, 1'b0);
    vecs[10] = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, ROW_ONE,  1'b1, 3'd1, 1'b0);
    vecs[11] = mkv(1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 128'h0,   1'b0, 3'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].ec, vecs[i].eh, 1'b0);
    end

    // Backpressure: 16 words with the consumer stalled, then drain in order
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, w(1, i), 1'b0, 1'b0);
      chk($sformatf("bp.cnt%0d", i),  128'(bus.row_count_o), 128'((i+1)/4));
      chk($sformatf("bp.hold%0d", i), 128'(bus.hold_req_o),  128'(((i+1)/4) >= 3));
    end
    for (int r = 0; r < 4; r++) begin
      drain_check($sformatf("bp.drain%0d", r), row(1, r), 3'(3 - r));
      chk($sformatf("bp.dhold%0d", r), 128'(bus.hold_req_o), 128'((3 - r) >= 3));
    end

    // Overflow: full FIFO, a fifth row stalls, one extra word is dropped
    fill_four(2);
    for (int i = 0; i < 4; i++) drive(1'b1, w(3, i), 1'b0, 1'b0);
    expect_out("ovf.stall", 1'b1, row(2, 0), 1'b0, 3'd4, 1'b1, 1'b0);
    drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    expect_out("ovf.drop", 1'b1, row(2, 0), 1'b0, 3'd4, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ovf.sticky", 128'(bus.overflow_err_o), 128'(1));
    drain_check("ovf.pop_push", row(2, 0), 3'd4);
    chk("ovf.hold_after", 128'(bus.hold_req_o), 128'(1));
    drain_check("ovf.d1", row(2, 1), 3'd3);
    drain_check("ovf.d2", row(2, 2), 3'd2);
    drain_check("ovf.d3", row(2, 3), 3'd1);
    drain_check("ovf.d4", row(3, 0), 3'd0);
    chk("ovf.still", 128'(bus.overflow_err_o), 128'(1));

    // Full FIFO, completing word with a same-cycle pop
    fill_four(4);
    for (int i = 0; i < 3; i++) drive(1'b1, w(5, i), 1'b0, 1'b0);
    drive(1'b1, w(5, 3), 1'b0, 1'b1);
    chk("pp.cnt", 128'(bus.row_count_o), 128'(4));
    drain_check("pp.d1", row(4, 1), 3'd3);
    drain_check("pp.d2", row(4, 2), 3'd2);
    drain_check("pp.d3", row(4, 3), 3'd1);
    drain_check("pp.d4", row(5, 0), 3'd0);
    chk("pp.empty", 128'(bus.row_valid_o), 128'(0));

    // Reset mid-fill with a queued row and a set overflow flag
    for (int i = 0; i < 4; i++) drive(1'b1, w(6, i), 1'b0, 1'b0);
    drive(1'b1, w(7, 0), 1'b0, 1'b0);
    drive(1'b1, w(7, 1), 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_out("rst", 1'b0, 128'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, w(8, i), 1'b0, 1'b1);
    chk("rst.no_early", 128'(bus.row_valid_o), 128'(0));
    drive(1'b1, w(8, 3), 1'b0, 1'b1);
    expect_out("rst.fresh", 1'b1, row(8, 0), 1'b0, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // Same sequence with flush, starting from three queued rows so hold is high
    for (int i = 0; i < 12; i++) drive(1'b1, w(9, i), 1'b0, 1'b0);
    drive(1'b1, w(10, 0), 1'b0, 1'b0);
    drive(1'b1, w(10, 1), 1'b0, 1'b0);
    chk("fl.pre_hold", 128'(bus.hold_req_o), 128'(1));
    bus.flush_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    bus.flush_i = 1'b0;
    expect_out("flush", 1'b0, 128'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, w(11, i), 1'b0, 1'b1);
    chk("fl.no_early", 128'(bus.row_valid_o), 128'(0));
    drive(1'b1, w(11, 3), 1'b0, 1'b1);
    expect_out("fl.fresh", 1'b1, row(11, 0), 1'b0, 3'd1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
